// File: rtl/vga_pkg.sv
// Shared types for the VGA test-pattern generator: pattern modes and the colour-bar palette.
package vga_pkg;

   typedef enum logic [2:0] {
      SOLID = 3'd0,
      QUAD  = 3'd1,
      BARS  = 3'd2,
      CHECK = 3'd3,
      MBAR  = 3'd4
   } tpg_mode_t;

   // One bit per channel; a set bit expands to full scale at the output width.
   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } rgb_t;

   localparam rgb_t BAR_PALETTE [8] = '{
      '{1'b1, 1'b1, 1'b1},
      '{1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b0}
   };

endpackage

// File: rtl/tpg_frame_timer.sv
// Per-frame state for the pattern generator: end-of-frame detect, latched mode,
// completed-frame counter and moving-bar position.
module tpg_frame_timer
   import vga_pkg::*;
#(
   parameter int COL_W    = 10,
   parameter int ROW_W    = 9,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int BAR_STEP = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [ROW_W-1:0] row,
   input  logic [COL_W-1:0] col,
   input  logic             blank,
   input  logic [2:0]       mode,
   output tpg_mode_t        mode_q,
   output logic [15:0]      frame_cnt_q,
   output logic [COL_W-1:0] bar_x_q
);

   logic             eof;
   logic [COL_W:0]   bar_sum;
   tpg_mode_t        mode_d;
   logic [15:0]      frame_cnt_d;
   logic [COL_W-1:0] bar_x_d;

   // The bar sum is one bit wider than bar_x so the wrap test cannot overflow.
   always_comb begin
      eof         = !blank && (row == ROW_W'(V_ACTIVE - 1)) && (col == COL_W'(H_ACTIVE - 1));
      bar_sum     = {1'b0, bar_x_q} + (COL_W + 1)'(BAR_STEP);
      mode_d      = mode_q;
      frame_cnt_d = frame_cnt_q;
      bar_x_d     = bar_x_q;
      if (eof) begin
         mode_d      = tpg_mode_t'(mode);
         frame_cnt_d = frame_cnt_q + 16'd1;
         bar_x_d     = (bar_sum >= (COL_W + 1)'(H_ACTIVE)) ? '0 : bar_sum[COL_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q      <= SOLID;
         frame_cnt_q <= '0;
         bar_x_q     <= '0;
      end else begin
         mode_q      <= mode_d;
         frame_cnt_q <= frame_cnt_d;
         bar_x_q     <= bar_x_d;
      end
   end

endmodule

// File: rtl/vga_pattern_gen.sv
// Mode-selectable VGA test-pattern generator with one-cycle registered outputs.
// Define VGA_TPG_BORDER_EN to overlay a 1-pixel white border on the active area.
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int COLOR_W  = 4,
   parameter int COL_W    = 10,
   parameter int ROW_W    = 9,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int CHK_LOG2 = 5,
   parameter int BAR_W    = 32,
   parameter int BAR_STEP = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [ROW_W-1:0]     row,
   input  logic [COL_W-1:0]     col,
   input  logic                 blank,
   input  logic                 hs_in,
   input  logic                 vs_in,
   input  logic [2:0]           mode,
   input  logic [3*COLOR_W-1:0] fg_color,
   output logic [COLOR_W-1:0]   vga_r,
   output logic [COLOR_W-1:0]   vga_g,
   output logic [COLOR_W-1:0]   vga_b,
   output logic                 hs_out,
   output logic                 vs_out,
   output logic                 blank_out,
   output logic [15:0]          frame_cnt
);

   localparam int BAR_PIX = H_ACTIVE / 8;
   localparam logic [COLOR_W-1:0] FULL = '1;
   localparam logic [COLOR_W-1:0] NONE = '0;

   tpg_mode_t            mode_q;
   logic [COL_W-1:0]     bar_x;
   logic [2:0]           bar_sel;
   rgb_t                 bar_color;
   logic [COL_W:0]       bar_end;
   logic [3*COLOR_W-1:0] pix;
   logic [3*COLOR_W-1:0] rgb_d, rgb_q;
   logic                 hs_q, vs_q, blank_q;

   tpg_frame_timer #(
      .COL_W    (COL_W),
      .ROW_W    (ROW_W),
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .BAR_STEP (BAR_STEP)
   ) u_timer (
      .clk         (clk),
      .reset_n     (reset_n),
      .row         (row),
      .col         (col),
      .blank       (blank),
      .mode        (mode),
      .mode_q      (mode_q),
      .frame_cnt_q (frame_cnt),
      .bar_x_q     (bar_x)
   );

   // Pattern select uses the frame-latched mode so a frame never mixes two patterns.
   always_comb begin
      bar_sel   = 3'(col / COL_W'(BAR_PIX));
      bar_color = BAR_PALETTE[bar_sel];
      bar_end   = {1'b0, bar_x} + (COL_W + 1)'(BAR_W);
      case (mode_q)
         SOLID:   pix = fg_color;
         QUAD:    pix = ((row < ROW_W'(V_ACTIVE / 2)) == (col < COL_W'(H_ACTIVE / 2)))
                        ? {FULL, NONE, NONE} : {NONE, NONE, FULL};
         BARS:    pix = {{COLOR_W{bar_color.r}}, {COLOR_W{bar_color.g}}, {COLOR_W{bar_color.b}}};
         CHECK:   pix = (col[CHK_LOG2] ^ row[CHK_LOG2]) ? '1 : '0;
         MBAR:    pix = ((col >= bar_x) && ({1'b0, col} < bar_end)) ? '1 : '0;
         default: pix = '0;
      endcase
`ifdef VGA_TPG_BORDER_EN
      if ((col == '0) || (col == COL_W'(H_ACTIVE - 1)) ||
          (row == '0) || (row == ROW_W'(V_ACTIVE - 1))) begin
         pix = '1;
      end
`endif
      rgb_d = blank ? '0 : pix;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rgb_q   <= '0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         blank_q <= 1'b1;
      end else begin
         rgb_q   <= rgb_d;
         hs_q    <= hs_in;
         vs_q    <= vs_in;
         blank_q <= blank;
      end
   end

   assign vga_r     = rgb_q[3*COLOR_W-1 -: COLOR_W];
   assign vga_g     = rgb_q[2*COLOR_W-1 -: COLOR_W];
   assign vga_b     = rgb_q[COLOR_W-1   -: COLOR_W];
   assign hs_out    = hs_q;
   assign vs_out    = vs_q;
   assign blank_out = blank_q;

endmodule
